// File: rtl/dac_serializer.sv
// Left-justified DAC serializer: buffers one stereo pair and shifts it out on DACDAT,
// timed by codec-mastered BCLK/DACLRCK. Optional DAC_MUTE_ON_UNDERRUN_EN plays silence on underrun.
module dac_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           BCLK,
  input  logic                           DACLRCK,
  input  logic signed [SAMPLE_WIDTH-1:0] leftSample,
  input  logic signed [SAMPLE_WIDTH-1:0] rightSample,
  input  logic                           sampleValid,
  output logic                           sampleReady,
  output logic                           DACDAT,
  output logic                           underrun
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SAMPLE_WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic [SYNC_STAGES-1:0]  bclk_sync;
  logic [SYNC_STAGES-1:0]  lrck_sync;
  logic                    bclk_hist;
  logic                    lrck_hist;
  logic [SYNC_STAGES:0]    primed;

  logic                    bclk_fall;
  logic                    lr_rise;
  logic                    lr_fall;

  logic [1:0]              state;
  logic                    hold_full;
  logic [SAMPLE_WIDTH-1:0] hold_l;
  logic [SAMPLE_WIDTH-1:0] hold_r;
  logic [SAMPLE_WIDTH-1:0] frame_l;
  logic [SAMPLE_WIDTH-1:0] frame_r;
  logic [SAMPLE_WIDTH-1:0] frame_l_nxt;
  logic [SAMPLE_WIDTH-1:0] frame_r_nxt;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]        bit_cnt;

  logic                    take_hold;
  logic                    bypass;
  logic                    starve;
  logic                    accept;

  // NOTE: every flop below uses non-blocking assignment so all registers see pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_hist <= 1'b0;
      lrck_hist <= 1'b0;
      primed    <= '0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], DACLRCK};
      bclk_hist <= bclk_sync[SYNC_STAGES-1];
      lrck_hist <= lrck_sync[SYNC_STAGES-1];
      primed    <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are masked until the history flop holds a real pin value, so a DACLRCK
  // that is already high when reset releases is not mistaken for a frame start.
  assign bclk_fall = primed[SYNC_STAGES] &  bclk_hist & ~bclk_sync[SYNC_STAGES-1];
  assign lr_rise   = primed[SYNC_STAGES] & ~lrck_hist &  lrck_sync[SYNC_STAGES-1];
  assign lr_fall   = primed[SYNC_STAGES] &  lrck_hist & ~lrck_sync[SYNC_STAGES-1];

  assign sampleReady = ~hold_full;

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    take_hold   = lr_rise &  hold_full;
    bypass      = lr_rise & ~hold_full &  sampleValid;
    starve      = lr_rise & ~hold_full & ~sampleValid;
    accept      = sampleValid & ~hold_full;
    frame_l_nxt = frame_l;
    frame_r_nxt = frame_r;
    if (take_hold) begin
      frame_l_nxt = hold_l;
      frame_r_nxt = hold_r;
    end else if (bypass) begin
      frame_l_nxt = leftSample;
      frame_r_nxt = rightSample;
    end else if (starve) begin
`ifdef DAC_MUTE_ON_UNDERRUN_EN
      frame_l_nxt = '0;
      frame_r_nxt = '0;
`else
      frame_l_nxt = frame_l;
      frame_r_nxt = frame_r;
`endif
    end
  end

  // NOTE: the small hold/frame buffers are reset too, so a reset discards buffered audio.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      frame_l   <= '0;
      frame_r   <= '0;
      underrun  <= 1'b0;
    end else begin
      frame_l  <= frame_l_nxt;
      frame_r  <= frame_r_nxt;
      underrun <= starve;
      if (take_hold) begin
        hold_full <= 1'b0;
      end else if (accept && !bypass) begin
        hold_full <= 1'b1;
        hold_l    <= leftSample;
        hold_r    <= rightSample;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (lr_rise) state <= ST_LEFT;
        ST_LEFT:  if (lr_fall) state <= ST_RIGHT;
        ST_RIGHT: if (lr_rise) state <= ST_LEFT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Channel edges take priority over a coincident BCLK fall so the MSB is never skipped.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      DACDAT    <= 1'b0;
    end else if (lr_rise) begin
      shift_reg <= frame_l_nxt;
      bit_cnt   <= CNT_LOAD;
      DACDAT    <= frame_l_nxt[SAMPLE_WIDTH-1];
    end else if (lr_fall && state == ST_LEFT) begin
      shift_reg <= frame_r;
      bit_cnt   <= CNT_LOAD;
      DACDAT    <= frame_r[SAMPLE_WIDTH-1];
    end else if (bclk_fall && state != ST_IDLE) begin
      if (bit_cnt != '0) begin
        shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], 1'b0};
        bit_cnt   <= bit_cnt - 1'b1;
        DACDAT    <= shift_reg[SAMPLE_WIDTH-2];
      end else begin
        DACDAT    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dac_serializer.md
# dac_serializer

Playback-side companion to the ADC deserializer: takes signed 16-bit left/right sample pairs from the effects datapath and shifts them out on the codec's DACDAT pin in left-justified format. BCLK and DACLRCK are driven by the codec (codec master mode). The block oversamples BCLK and DACLRCK on the system clock and buffers one sample pair, so the effects chain can hand samples over at any time within a frame.

## Interface
- SAMPLE_WIDTH, 16: bits per channel.
- SYNC_STAGES, 2: synchronizer flops on BCLK and DACLRCK (≥2).

- CLK  input  1  system clock (50 MHz); the only clock. All flops use the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- BCLK  input  1  codec bit clock, asynchronous to CLK.
- DACLRCK  input  1  codec frame clock: 1 = left channel, 0 = right channel.
- leftSample  input  SAMPLE_WIDTH  signed left sample.
- rightSample  input  SAMPLE_WIDTH  signed right sample.
- sampleValid  input  1  sample pair offered.
- sampleReady  output  1  hold buffer empty; the pair is accepted when sampleValid && sampleReady.
- DACDAT  output  1  serial data to the codec.
- underrun  output  1  one-CLK pulse when a frame starts with no new pair available.

## Operation
- BCLK and DACLRCK each pass through SYNC_STAGES flops, plus one history flop for edge detection.
- Events derived from the synchronized signals: bclkFall, lrRise (frame start, left), lrFall (right).
- Hold buffer: one pair (holdL, holdR) plus holdFull. sampleReady = !holdFull.
- State machine:
  - IDLE: DACDAT = 0. On lrRise, go to LEFT.
  - LEFT: on lrFall, go to RIGHT.
  - RIGHT: on lrRise, go to LEFT.
  - There is no other exit. A reset returns the machine to IDLE.
- On every lrRise (including the one leaving IDLE):
  - If holdFull: the pair moves to the frame registers (frameL, frameR) and holdFull clears.
  - Else if sampleValid is high in the same cycle: the incoming pair bypasses the hold buffer into frameL/frameR, with no underrun.
  - Otherwise: underrun pulses and the frame registers keep their last contents (see Configuration).
- Channel start (lrRise → frameL; lrFall → frameR):
  - The selected word loads into the shift register, bit counter = SAMPLE_WIDTH-1.
  - DACDAT = MSB in the same cycle the edge is detected.
- Each bclkFall while the bit counter > 0: shift left, DACDAT = next bit, decrement the counter.
- After the LSB has been driven, the next bclkFall drives DACDAT = 0 until the next LRCK edge (padding bits are zero).
- If an LRCK edge arrives before all bits are sent, the word is truncated and the new channel starts immediately. No error is flagged.
- A bclkFall coinciding with an LRCK edge: the LRCK edge wins and the MSB is driven.
- Accepting a pair (sampleValid && sampleReady) sets holdFull in the next cycle.
- Acceptance in the same cycle as an lrRise that consumes the bypass path leaves holdFull = 0.
- Samples are passed through unmodified (two's complement, MSB first).

## Timing
- Reset values: DACDAT = 0, sampleReady = 1, underrun = 0, state = IDLE, holdFull = 0, frameL = frameR = 0, shift register = 0.
- Latency from a BCLK/DACLRCK pin edge to DACDAT update: SYNC_STAGES+1 CLK cycles (3 at default).
- Requirements on the codec clocks: BCLK high and low each ≥ SYNC_STAGES+2 CLK cycles; DACLRCK changes only on BCLK falling edges.
- sampleReady deasserts 1 cycle after acceptance and reasserts 1 cycle after the lrRise that empties the buffer.
- A reset mid-frame immediately drives DACDAT = 0 and discards buffered data. Output resumes at the first lrRise after RESET_N is released.

## Configuration
- DAC_MUTE_ON_UNDERRUN_EN defined: on underrun, frameL and frameR are cleared to 0, so the frame plays silence.
- DAC_MUTE_ON_UNDERRUN_EN undefined: on underrun, frameL and frameR keep their previous values, so the last pair repeats.
- underrun pulses in both builds.

## Test plan
- Basic frame: load L = 16'hA5C3, R = 16'h0F0F, then run a 48-BCLK frame → DACDAT carries A5C3 MSB-first in the first 16 left bits, zero padding, then 0F0F in the first 16 right bits. sampleReady returns to 1 after lrRise.
- Underrun: no pair loaded before the second frame.
  - underrun pulses once.
  - With the macro: all-zero frame.
  - Without the macro: the A5C3/0F0F frame repeats.
- Bypass: sampleValid with L = 16'h8001, R = 16'h7FFE asserted in the exact cycle of lrRise, hold empty → no underrun, 8001 is driven immediately, holdFull stays 0.
- Back-pressure: offer three pairs within one frame → only the first is accepted. sampleReady stays 0 until the next lrRise, then the second pair is accepted.
- Short frame: DACLRCK falls after 10 left bits → the left word is truncated, and the right MSB appears SYNC_STAGES+1 cycles after the pin edge.
- Reset mid-word: drop RESET_N at left bit 7 → DACDAT = 0 at once, sampleReady = 1, and there is no output until the first lrRise after release.
